// File: rtl/multiprecision_add_seq_pkg.sv
// Shared definitions for the limb-serial wide adder.
//   state_e    : controller state encoding (IDLE/RUN/DONE, 2 bits)
//   idx_width  : limb counter width, max(1, clog2(limbs))
package multiprecision_add_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A single-limb configuration still needs a 1-bit counter
  function automatic int unsigned idx_width(input int unsigned limbs);
    return (limbs > 1) ? $clog2(limbs) : 1;
  endfunction

endpackage

// File: rtl/nbit_full_adder.sv
// N-bit ripple adder with carry-in and carry-out.
//   a_i, b_i : N-bit addends
//   c_i      : carry in
//   sum_o    : N-bit sum
//   c_o      : carry out of the MSB
module nbit_full_adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  output logic [N-1:0] sum_o,
  output logic         c_o
);

  logic [N:0] full;

  // Extend to N+1 bits so the carry falls out as the top bit
  assign full  = {1'b0, a_i} + {1'b0, b_i} + (N+1)'(c_i);
  assign sum_o = full[N-1:0];
  assign c_o   = full[N];

endmodule

// File: rtl/multiprecision_add_seq.sv
// Wide (N*LIMBS-bit) add/subtract computed one N-bit limb per cycle through a
// single shared adder, LSB limb first, with the inter-limb carry registered.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   a, b, c_in, op_sub   : operands; op_sub=1 computes a-b and ignores c_in
//   out_valid / out_ready: result handshake (valid only in DONE)
//   sum, c_out           : W-bit result and carry out of the top limb
module multiprecision_add_seq
  import multiprecision_add_seq_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned LIMBS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*LIMBS-1:0]   a,
  input  logic [N*LIMBS-1:0]   b,
  input  logic                 c_in,
  input  logic                 op_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*LIMBS-1:0]   sum,
  output logic                 c_out
);

  localparam int unsigned W     = N * LIMBS;
  localparam int unsigned IDX_W = idx_width(LIMBS);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     sum_q;
  logic             c_out_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [N-1:0]     a_limb;
  logic [N-1:0]     b_limb;
  logic [N-1:0]     add_sum;
  logic             add_carry;
  logic             last_limb;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;

  assign last_limb = (idx_q == IDX_W'(LIMBS - 1));

  // Select the current limb of each captured operand
  always_comb begin
    a_limb = '0;
    b_limb = '0;
    for (int unsigned i = 0; i < LIMBS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_limb = a_q[i*N +: N];
        b_limb = b_q[i*N +: N];
      end
    end
  end

  nbit_full_adder #(
    .N (N)
  ) u_adder (
    .a_i   (a_limb),
    .b_i   (b_limb),
    .c_i   (carry_q),
    .sum_o (add_sum),
    .c_o   (add_carry)
  );

  // Controller: capture, limb-serial accumulate, hold result until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            // Subtract is a + ~b + 1: invert B here and seed the carry with 1
            a_q        <= a;
            b_q        <= op_sub ? ~b : b;
            carry_q    <= op_sub ? 1'b1 : c_in;
            idx_q      <= '0;
            sum_q      <= '0;
            state_q    <= ST_RUN;
            in_ready_q <= 1'b0;
          end
        end
        ST_RUN: begin
          for (int unsigned i = 0; i < LIMBS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              sum_q[i*N +: N] <= add_sum;
            end
          end
          carry_q <= add_carry;
          if (last_limb) begin
            c_out_q     <= add_carry;
            idx_q       <= '0;
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiprecision_add_seq.sv
// Scoreboard bench for multiprecision_add_seq at N=8/LIMBS=4 and N=8/LIMBS=1.
module tb_multiprecision_add_seq;

  localparam int unsigned N  = 8;
  localparam int unsigned L  = 4;
  localparam int unsigned W  = N * L;
  localparam int unsigned W1 = N;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, c_in, op_sub, out_valid, out_ready, c_out;
  logic [W-1:0]  a, b, sum;
  logic          in_valid1, in_ready1, c_in1, op_sub1, out_valid1, out_ready1, c_out1;
  logic [W1-1:0] a1, b1, sum1;

  multiprecision_add_seq #(.N(N), .LIMBS(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .op_sub(op_sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out)
  );

  multiprecision_add_seq #(.N(N), .LIMBS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .c_in(c_in1), .op_sub(op_sub1), .out_valid(out_valid1),
    .out_ready(out_ready1), .sum(sum1), .c_out(c_out1)
  );

  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t exp1_q[$];
  int   acc_cyc = 0, prev_acc = -1, acc1_cyc = 0;
  bit   b2b = 1'b0;
  logic ov_prev = 1'b0, ov1_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor for the 4-limb instance: latency, initiation interval, results
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        if (b2b && prev_acc >= 0) check("ii", W'(cyc + 1 - prev_acc), W'(L + 2));
        prev_acc = cyc + 1;
        acc_cyc  = cyc + 1;
      end
      if (out_valid && !ov_prev) check("latency", W'(cyc - acc_cyc), W'(L));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_result: got sum 0x%0h with nothing expected", sum);
        end else begin
          e = exp_q.pop_front();
          check("sum", sum, e.s);
          check("c_out", W'(c_out), W'(e.c));
        end
      end
    end
    ov_prev = out_valid;
  end

  // Monitor for the single-limb instance
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (in_valid1 && in_ready1) acc1_cyc = cyc + 1;
      if (out_valid1 && !ov1_prev) check("latency1", W'(cyc - acc1_cyc), W'(1));
      if (out_valid1 && out_ready1) begin
        if (exp1_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_result1: got sum 0x%0h with nothing expected", sum1);
        end else begin
          e = exp1_q.pop_front();
          check("sum1", W'(sum1), e.s);
          check("c_out1", W'(c_out1), W'(e.c));
        end
      end
    end
    ov1_prev = out_valid1;
  end

  // Present one operand and return just after the accepting edge
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input logic ts, input bit keep);
    int n;
    n = 0;
    a = ta; b = tb; c_in = tc; op_sub = ts; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic send1(input logic [W1-1:0] ta, input logic [W1-1:0] tb, input logic tc,
                       input logic ts);
    int n;
    n = 0;
    a1 = ta; b1 = tb; c_in1 = tc; op_sub1 = ts; in_valid1 = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready1) break;
      n++;
      if (n > 50) begin
        checks++;
        $display("FAIL accept1_timeout: in_ready stayed 0 for %0d cycles", n);
        in_valid1 = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 || exp1_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        checks++;
        $display("FAIL drain_timeout: %0d/%0d results still pending", exp_q.size(), exp1_q.size());
        exp_q.delete();
        exp1_q.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic ms);
    logic [W:0] r;
    r = {1'b0, ma} + {1'b0, (ms ? ~mb : mb)} + (W+1)'(ms ? 1'b1 : mc);
    return '{s: r[W-1:0], c: r[W]};
  endfunction

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    int           n;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; op_sub = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0; op_sub1 = 1'b0; out_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_sum", sum, W'(0));
    check("rst_c_out", W'(c_out), W'(0));
    rst_n = 1'b1;

    // Directed adds and subtracts
    exp_q.push_back('{s: 32'h0000_0100, c: 1'b0});
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    drain();
    exp_q.push_back('{s: 32'h0000_0000, c: 1'b1});
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    drain();
    exp_q.push_back('{s: 32'hFFFF_FFFE, c: 1'b0});
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0);
    drain();
    exp_q.push_back('{s: 32'h0000_0002, c: 1'b1});
    send(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 1'b0);
    drain();

    // Backpressure: result must hold while a competing request is ignored
    out_ready = 1'b0;
    exp_q.push_back('{s: 32'hACF1_3568, c: 1'b0});
    send(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    if (!out_valid) begin
      checks++;
      $display("FAIL done_timeout: out_valid got 0 required 1");
    end
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("bp_out_valid", W'(out_valid), W'(1));
      check("bp_sum", sum, 32'hACF1_3568);
      check("bp_c_out", W'(c_out), W'(0));
      check("bp_in_ready", W'(in_ready), W'(0));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", W'(in_ready), W'(1));
    check("rel_out_valid", W'(out_valid), W'(0));
    drain();

    // Reset while limb 2 is next to be processed discards the operation
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_rst_out_valid", W'(out_valid), W'(0));
    check("mid_rst_in_ready", W'(in_ready), W'(1));
    check("mid_rst_sum", sum, W'(0));
    check("mid_rst_c_out", W'(c_out), W'(0));
    exp_q.push_back('{s: 32'h0000_0002, c: 1'b0});
    send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    drain();

    // Single-limb configuration
    exp1_q.push_back('{s: 32'h0000_0000, c: 1'b1});
    send1(8'hFF, 8'h01, 1'b0, 1'b0);
    drain();
    exp1_q.push_back('{s: 32'h0000_00F0, c: 1'b0});
    send1(8'h10, 8'h20, 1'b1, 1'b1);
    drain();

    // Back-to-back random stream with in_valid and out_ready held high
    b2b = 1'b1;
    prev_acc = -1;
    for (int k = 0; k < 8; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(1));
      rs = 1'($urandom_range(1));
      exp_q.push_back(model(ra, rb, rc, rs));
      send(ra, rb, rc, rs, 1'b1);
    end
    in_valid = 1'b0;
    drain();
    b2b = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/multiprecision_add_seq.md
Name: multiprecision_add_seq

Overview:
- Sequencer that performs a wide add/subtract (N*LIMBS bits) by time-multiplexing one N-bit ripple adder, one limb per cycle, LSB limb first.
- The carry between limbs is held in a register.
- Sits between an operand producer and a result consumer, with a valid/ready handshake on each side.
- Trades latency for area relative to one full-width adder.

Parameters:
- N, 8, limb width in bits (width of the shared adder); N >= 1.
- LIMBS, 4, limbs per operand; LIMBS >= 1. Full operand width W = N*LIMBS.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept an operand.
- a  in  W  operand A.
- b  in  W  operand B.
- c_in  in  1  carry-in for add; ignored when op_sub=1.
- op_sub  in  1  0: sum = a+b+c_in; 1: sum = a-b (a + ~b + 1).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  W  result.
- c_out  out  1  carry out of MSB limb (sub: 1 = no borrow).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, limb index=0, carry reg=0, captured operands=0.
  - sum=0, c_out=0, out_valid=0, in_ready=1 after that edge.
  - Applies from any state: an operation in progress is discarded and produces no result.
- States: IDLE, RUN, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE:
  - On an edge with in_valid=1, capture a, and b (or ~b if op_sub).
  - Carry reg <= (op_sub ? 1 : c_in); limb index <= 0; sum <= 0; go to RUN.
  - Otherwise stay in IDLE.
  - Inputs sampled only at the accepting edge; later changes are ignored.
- RUN:
  - Adder inputs: captured A limb[idx], captured B' limb[idx], carry reg.
  - Each edge: sum limb[idx] <= adder sum; carry reg <= adder carry; idx++.
  - On the edge processing idx=LIMBS-1: c_out <= adder carry, go to DONE, idx wraps to 0.
  - RUN lasts exactly LIMBS cycles.
  - No early exit; all limbs are always processed, so latency is data-independent.
- DONE:
  - out_valid=1; sum and c_out held stable while out_ready=0, for any number of cycles.
  - On an edge with out_ready=1, go to IDLE.
  - sum and c_out keep their values until the next accept.
- Latency: out_valid rises LIMBS cycles after the accepting edge.
- Initiation interval: LIMBS+2 cycles with out_ready=1 and in_valid held high.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Width rules:
  - Arithmetic is modulo 2^W; c_out is bit W of the true result.
  - Subtract results are two's complement.
  - LIMBS=1: single RUN cycle, then DONE.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE/RUN/DONE (2-bit);
  - a clog2-based index-width function for the limb counter (width max(1, clog2(LIMBS))).
- One sub-module instance: the team's existing nbit_full_adder with parameter N. It is the shared adder, with c_in = carry reg.
- Limb select and limb write-back use indexed part-selects in the controller. No further sub-modules.

Test Plan:
- N=8, LIMBS=4 for all cases unless noted.
- Add, no wrap: a=0x000000FF, b=0x00000001, c_in=0, op_sub=0 -> sum=0x00000100, c_out=0; out_valid exactly 4 cycles after accept.
- Full ripple: a=0xFFFFFFFF, b=0x00000000, c_in=1 -> sum=0x00000000, c_out=1. Also a=0x12345678, b=0x9ABCDEF0, c_in=0 -> sum=0xACF13568, c_out=0.
- Subtract:
  - a=5, b=7, op_sub=1, c_in=1 (must be ignored) -> sum=0xFFFFFFFE, c_out=0.
  - a=7, b=5 -> sum=0x00000002, c_out=1.
- Backpressure:
  - Hold out_ready=0 for 6 cycles in DONE -> out_valid=1, sum/c_out stable, in_ready=0, new in_valid ignored.
  - Then out_ready=1 -> next cycle in_ready=1, out_valid=0.
- Reset mid-operation: assert rst_n=0 for one edge during RUN at idx=2 -> after that edge out_valid=0, in_ready=1, sum=0, c_out=0. A following op a=1, b=1 gives sum=2.
- Back-to-back and LIMBS=1: with in_valid and out_ready tied 1, verify accepts every 6 cycles with correct results for a random stream checked against a W-bit reference model. Repeat at N=8, LIMBS=1: a=0xFF, b=0x01 -> sum=0x00, c_out=1, latency 1.
